// File: rtl/osd_pkg.sv
// Shared types for the OSD write scheduler: write payload, FSM states and fixed addresses.
package osd_pkg;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
    } osd_wr_t;

    typedef enum logic [1:0] {IDLE, DRAIN, HOLD} sched_state_t;

    localparam logic [3:0] OSD_CFG_ADDR = 4'h0;

endpackage

// File: rtl/osd_wr_fifo.sv
// First-word-fall-through FIFO of OSD writes with registered count/full/empty.
module osd_wr_fifo
    import osd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          vclk,
    input  logic          rst_i,
    input  logic          push,
    input  osd_wr_t       push_data,
    input  logic          pop,
    output osd_wr_t       pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    osd_wr_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]   count_reg, count_next;
    logic            full_reg, empty_reg;
    logic            push_ok, pop_ok;

    // Full is taken from the registered occupancy, so a same-cycle pop never frees a slot early.
    assign push_ok    = push && !full_reg;
    assign pop_ok     = pop && !empty_reg;
    assign count_next = count_reg + CW'(push_ok) - CW'(pop_ok);

    always_ff @(posedge vclk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge vclk or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            full_reg  <= (count_next == CW'(DEPTH));
            empty_reg <= (count_next == '0);
        end
    end

    assign pop_data = mem[rd_ptr_reg];
    assign full     = full_reg;
    assign empty    = empty_reg;
    assign count    = count_reg;

endmodule

// File: rtl/osd_update_sched.sv
// Vblank-synchronous OSD register write scheduler with per-blank write budget.
// Optional alert requester and round-robin arbiter enabled by OSD_SCHED_ALERT_EN.
module osd_update_sched
    import osd_pkg::*;
#(
    parameter int FIFO_DEPTH       = 4,
    parameter int MAX_WR_PER_BLANK = 16
) (
    input  logic        vclk,
    input  logic        rst_i,
    input  logic        vblank,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic [3:0]  host_addr,
    input  logic [31:0] host_data,
    input  logic [3:0]  host_be,
    input  logic        alert_valid,
    output logic        alert_ready,
    input  logic [3:0]  alert_addr,
    input  logic [31:0] alert_data,
    input  logic [3:0]  alert_be,
    output logic        osd_wr,
    output logic [3:0]  osd_wr_addr,
    output logic [31:0] osd_wr_data,
    output logic [3:0]  osd_wr_be,
    output logic        sched_busy
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    sched_state_t  state_reg, state_next;
    logic [7:0]    budget_reg, budget_next;
    logic          vblank_q_reg, armed_reg;
    logic          osd_wr_reg, busy_reg, busy_next;
    osd_wr_t       out_reg, host_wr, fifo_head, alert_slot, sel_wr;
    logic          fifo_full, fifo_empty, host_push;
    logic [CW-1:0] fifo_count, fifo_count_next;
    logic          grant, grant_alert, grant_host, pick_alert;
    logic          alert_pending, alert_pending_next;

    assign host_wr    = {host_addr, host_data, host_be};
    assign host_ready = !fifo_full;
    assign host_push  = host_valid && !fifo_full;

    osd_wr_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
        .vclk      (vclk),
        .rst_i     (rst_i),
        .push      (host_push),
        .push_data (host_wr),
        .pop       (grant_host),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef OSD_SCHED_ALERT_EN
    logic    alert_pending_reg, last_alert_reg, alert_push;
    osd_wr_t alert_slot_reg;

    assign alert_push = alert_valid && !alert_pending_reg;

    always_ff @(posedge vclk or posedge rst_i) begin
        if (rst_i) begin
            alert_pending_reg <= 1'b0;
            alert_slot_reg    <= '0;
            last_alert_reg    <= 1'b0;
        end else begin
            if (alert_push) begin
                alert_pending_reg <= 1'b1;
                alert_slot_reg    <= {alert_addr, alert_data, alert_be};
            end else if (grant_alert) begin
                alert_pending_reg <= 1'b0;
            end
            if (grant)
                last_alert_reg <= grant_alert;
        end
    end

    // Alert wins when it is the only source or when host had the last grant.
    assign pick_alert         = alert_pending_reg && (fifo_empty || !last_alert_reg);
    assign alert_pending      = alert_pending_reg;
    assign alert_pending_next = alert_push || (alert_pending_reg && !grant_alert);
    assign alert_slot         = alert_slot_reg;
    assign alert_ready        = !alert_pending_reg;
`else
    logic unused_alert;
    assign unused_alert       = ^{alert_valid, alert_addr, alert_data, alert_be};
    assign pick_alert         = 1'b0;
    assign alert_pending      = 1'b0;
    assign alert_pending_next = 1'b0;
    assign alert_slot         = '0;
    assign alert_ready        = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        budget_next = budget_reg;
        grant       = 1'b0;
        grant_alert = 1'b0;
        case (state_reg)
            IDLE: begin
                if (vblank && !vblank_q_reg && armed_reg) begin
                    state_next  = DRAIN;
                    budget_next = '0;
                end
            end
            DRAIN: begin
                if (!vblank) begin
                    state_next = IDLE;
                end else if (!fifo_empty || alert_pending) begin
                    grant       = 1'b1;
                    grant_alert = pick_alert;
                    if (budget_reg == 8'(MAX_WR_PER_BLANK - 1))
                        state_next = HOLD;
                    else
                        budget_next = budget_reg + 8'd1;
                end
            end
            HOLD: begin
                if (!vblank)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign grant_host      = grant && !grant_alert;
    assign sel_wr          = grant_alert ? alert_slot : fifo_head;
    assign fifo_count_next = fifo_count + CW'(host_push) - CW'(grant_host);
    assign busy_next       = (fifo_count_next != '0) || alert_pending_next;

    // armed_reg blocks a false edge when vblank is already high as reset releases.
    always_ff @(posedge vclk or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            budget_reg   <= '0;
            vblank_q_reg <= 1'b0;
            armed_reg    <= 1'b0;
            osd_wr_reg   <= 1'b0;
            out_reg      <= '0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            budget_reg   <= budget_next;
            vblank_q_reg <= vblank;
            armed_reg    <= armed_reg || !vblank;
            osd_wr_reg   <= grant;
            busy_reg     <= busy_next;
            if (grant)
                out_reg <= sel_wr;
        end
    end

    assign osd_wr      = osd_wr_reg;
    assign osd_wr_addr = out_reg.addr;
    assign osd_wr_data = out_reg.data;
    assign osd_wr_be   = out_reg.be;
    assign sched_busy  = busy_reg;

endmodule
